// File: rtl/jelly_priority_queue.sv
// Sorted-array priority queue. Slot 0 holds the entry with the smallest
// priority value. Equal priorities keep their insertion order.
module jelly_priority_queue #(
  parameter int N         = 16,
  parameter int ID_WIDTH  = 32,
  parameter int PRI_WIDTH = 4,
  parameter int N_WIDTH   = $clog2(N+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 in_op,
  input  logic [ID_WIDTH-1:0]  in_id,
  input  logic [PRI_WIDTH-1:0] in_pri,
  input  logic                 in_valid,
  output logic [ID_WIDTH-1:0]  top_id,
  output logic [PRI_WIDTH-1:0] top_pri,
  output logic                 top_valid,
  output logic [N_WIDTH-1:0]   size
);

  logic [ID_WIDTH-1:0]  slot_id  [N];
  logic [PRI_WIDTH-1:0] slot_pri [N];
  logic [ID_WIDTH-1:0]  next_id  [N];
  logic [PRI_WIDTH-1:0] next_pri [N];
  logic [N_WIDTH-1:0]   size_next;
  logic [N-1:0]         le_mask;
  logic [N-1:0]         hit_upto;
  logic                 hit;

  always_comb begin
    next_id   = slot_id;
    next_pri  = slot_pri;
    size_next = size;
    le_mask   = '0;
    hit_upto  = '0;
    hit       = 1'b0;

    // le_mask marks the occupied prefix that stays ahead of a new entry;
    // hit_upto marks slots at or after the first id match.
    for (int i = 0; i < N; i++) begin
      le_mask[i]  = (i < int'(size)) && (slot_pri[i] <= in_pri);
      hit         = hit | ((i < int'(size)) && (slot_id[i] == in_id));
      hit_upto[i] = hit;
    end

    if (in_valid) begin
      if (!in_op) begin
        if (int'(size) < N) begin
          if (!le_mask[0]) begin
            next_id[0]  = in_id;
            next_pri[0] = in_pri;
          end
          for (int i = 1; i < N; i++) begin
            if (!le_mask[i]) begin
              if (le_mask[i-1]) begin
                next_id[i]  = in_id;
                next_pri[i] = in_pri;
              end else begin
                next_id[i]  = slot_id[i-1];
                next_pri[i] = slot_pri[i-1];
              end
            end
          end
          size_next = size + N_WIDTH'(1);
        end
      end else if (hit) begin
        // Unoccupied slots are always zero, so shifting them up clears the tail.
        for (int i = 0; i < N-1; i++) begin
          if (hit_upto[i]) begin
            next_id[i]  = slot_id[i+1];
            next_pri[i] = slot_pri[i+1];
          end
        end
        next_id[N-1]  = '0;
        next_pri[N-1] = '0;
        size_next     = size - N_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        slot_id[i]  <= '0;
        slot_pri[i] <= '0;
      end
      size      <= '0;
      top_valid <= 1'b0;
    end else if (cke) begin
      slot_id   <= next_id;
      slot_pri  <= next_pri;
      size      <= size_next;
      top_valid <= (size_next != '0);
    end
  end

  assign top_id  = slot_id[0];
  assign top_pri = slot_pri[0];

endmodule

// File: tb/tb_jelly_priority_queue.sv
// Bench for jelly_priority_queue: directed and random commands against a
// queue-based reference model, checked by a monitor draining an expected queue.
module tb_jelly_priority_queue;
  localparam int N   = 16;
  localparam int IDW = 32;
  localparam int PW  = 4;
  localparam int NW  = $clog2(N+1);
  localparam int W   = NW + 1 + IDW + PW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cke = 1'b0;
  logic           in_op = 1'b0;
  logic           in_valid = 1'b0;
  logic [IDW-1:0] in_id = '0;
  logic [PW-1:0]  in_pri = '0;
  logic [IDW-1:0] top_id;
  logic [PW-1:0]  top_pri;
  logic           top_valid;
  logic [NW-1:0]  size;

  jelly_priority_queue #(.N(N), .ID_WIDTH(IDW), .PRI_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .cke(cke), .in_op(in_op), .in_id(in_id),
    .in_pri(in_pri), .in_valid(in_valid), .top_id(top_id), .top_pri(top_pri),
    .top_valid(top_valid), .size(size)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: entries kept in priority order, FIFO among equals
  logic [IDW-1:0] m_id[$];
  logic [PW-1:0]  m_pri[$];
  logic [W-1:0]   exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] model_out();
    if (m_id.size() == 0) return '0;
    return {NW'(m_id.size()), 1'b1, m_id[0], m_pri[0]};
  endfunction

  task automatic drive(input logic r, input logic c, input logic v, input logic op,
                       input logic [IDW-1:0] id, input logic [PW-1:0] pri);
    @(negedge clk);
    reset = r; cke = c; in_valid = v; in_op = op; in_id = id; in_pri = pri;
    if (r) begin
      m_id.delete();
      m_pri.delete();
    end else if (c && v) begin
      if (!op) begin
        if (m_id.size() < N) begin
          int pos;
          pos = 0;
          for (int i = 0; i < m_id.size(); i++)
            if (m_pri[i] <= pri) pos = i + 1;
          m_id.insert(pos, id);
          m_pri.insert(pos, pri);
        end
      end else begin
        for (int i = 0; i < m_id.size(); i++) begin
          if (m_id[i] == id) begin
            m_id.delete(i);
            m_pri.delete(i);
            break;
          end
        end
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic add(input logic [IDW-1:0] id, input logic [PW-1:0] pri);
    drive(1'b0, 1'b1, 1'b1, 1'b0, id, pri);
  endtask

  task automatic del(input logic [IDW-1:0] id);
    drive(1'b0, 1'b1, 1'b1, 1'b1, id, PW'(0));
  endtask

  // monitor: outputs are valid every cycle; compare just after each edge
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {size, top_valid, top_id, top_pri};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL state t=%0t: got size=%0d valid=%0b id=%h pri=%h, want size=%0d valid=%0b id=%h pri=%h",
                   $time, act[W-1 -: NW], act[IDW+PW], act[PW +: IDW], act[PW-1:0],
                   exp[W-1 -: NW], exp[IDW+PW], exp[PW +: IDW], exp[PW-1:0]);
        end
      end
    end
  end

  initial begin
    int budget;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

    add(32'h102, 4'd2); add(32'h103, 4'd3); add(32'h101, 4'd1);
    del(32'h102); del(32'h103); del(32'h101);

    for (int k = 0; k < 16; k++) add(32'h100 + IDW'(k), PW'(k));
    add(32'h1FF, 4'd0);
    for (int k = 0; k < 16; k++) del(32'h100 + IDW'(k));
    del(32'h100);

    add(32'hA, 4'd5); add(32'hB, 4'd5); add(32'hC, 4'd5);
    del(32'hD); del(32'hA);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h56, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hB, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h57, 4'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h58, 4'd0);

    // random phases: add-heavy, balanced, delete-heavy
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 400; n++) begin
        logic r, c, v, op;
        r  = ($urandom_range(0, 149) == 0);
        c  = ($urandom_range(0, 9) != 0);
        v  = ($urandom_range(0, 4) != 0);
        op = ($urandom_range(0, 9) < (ph % 3) * 3 + 2);
        drive(r, c, v, op, IDW'($urandom_range(0, 9)), PW'($urandom_range(0, 15)));
      end
    end

    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
